// File: rtl/sort4_pkg.sv
// Shared constants and state encoding for the 4-entry descending sorter.
package sort4_pkg;

    localparam int N_ENTRIES = 4;
    localparam int N_PHASES  = 4;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/sort4_desc_cmp_swap.sv
// Combinational compare-swap cell: larger word on hi_out, smaller on lo_out.
// Words swap only on strict less-than, so equal words keep their order.
module cmp_swap #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic swap;

    assign swap   = (hi_in < lo_in);
    assign hi_out = swap ? lo_in : hi_in;
    assign lo_out = swap ? hi_in : lo_in;

endmodule

// File: rtl/sort4_desc.sv
// Sequential 4-entry sorter: loads four words, runs four odd-even transposition
// phases, then streams the words out largest-first over valid/ready.
module sort4_desc
    import sort4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam logic [1:0] LAST_CNT   = 2'(N_ENTRIES - 1);
    localparam logic [1:0] LAST_PHASE = 2'(N_PHASES - 1);

    state_t           state;
    logic [WIDTH-1:0] slot [N_ENTRIES];
    logic [1:0]       cnt;
    logic [1:0]       phase;
    logic [1:0]       idx;

    logic             accept;
    logic             take;
    logic             odd_phase;
    logic [WIDTH-1:0] a_hi_in, a_lo_in, a_hi_out, a_lo_out;
    logic [WIDTH-1:0] b_hi_out, b_lo_out;

    // in_ready depends only on the state register (and reset), never on out_ready.
    assign in_ready  = rst_n && (state == LOAD);
    assign accept    = in_valid && in_ready;
    assign take      = out_valid && out_ready;
    assign odd_phase = phase[0];
    assign busy      = (state != LOAD);
    assign out_data  = slot[idx];
    assign out_last  = out_valid && (idx == LAST_CNT);

    // Cell A serves pair (0,1) on even phases and is reused for pair (1,2) on odd phases.
    assign a_hi_in = odd_phase ? slot[1] : slot[0];
    assign a_lo_in = odd_phase ? slot[2] : slot[1];

    cmp_swap #(.WIDTH(WIDTH)) u_cs_a (
        .hi_in  (a_hi_in),
        .lo_in  (a_lo_in),
        .hi_out (a_hi_out),
        .lo_out (a_lo_out)
    );

    cmp_swap #(.WIDTH(WIDTH)) u_cs_b (
        .hi_in  (slot[2]),
        .lo_in  (slot[3]),
        .hi_out (b_hi_out),
        .lo_out (b_lo_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= LOAD;
            cnt       <= 2'd0;
            phase     <= 2'd0;
            idx       <= 2'd0;
            out_valid <= 1'b0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                slot[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        slot[cnt] <= in_data;
                        cnt       <= cnt + 2'd1;
                        if (cnt == LAST_CNT) begin
                            state <= SORT;
                            phase <= 2'd0;
                        end
                    end
                end
                SORT: begin
                    if (odd_phase) begin
                        slot[1] <= a_hi_out;
                        slot[2] <= a_lo_out;
                    end else begin
                        slot[0] <= a_hi_out;
                        slot[1] <= a_lo_out;
                        slot[2] <= b_hi_out;
                        slot[3] <= b_lo_out;
                    end
                    phase <= phase + 2'd1;
                    if (phase == LAST_PHASE) begin
                        state     <= DRAIN;
                        idx       <= 2'd0;
                        out_valid <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (take) begin
                        idx <= idx + 2'd1;
                        if (idx == LAST_CNT) begin
                            state     <= LOAD;
                            cnt       <= 2'd0;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= LOAD;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort4_desc.sv
// Scoreboard bench for sort4_desc: expected descending order is queued at load
// time and popped by a negedge monitor on every output handshake.
module tb_sort4_desc;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;

    logic [8:0] sb [$];
    logic [8:0] mon_e;

    sort4_desc #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Output monitor: a handshake seen at the negedge completes on the next posedge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(mon_e[7:0]));
                chk("out_last", 32'(out_last), 32'(mon_e[8]));
            end
        end
    end

    task automatic load_word(input logic [7:0] w, input int gap);
        logic rdy;
        int   n;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = w;
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 200) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy) chk("accept_timeout", 32'd0, 32'd1);
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic load_batch(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d, input int gmax);
        logic [7:0] w [4];
        logic [7:0] s [4];
        logic [7:0] t;
        w = '{a, b, c, d};
        s = w;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (s[j] < s[j+1]) begin
                    t = s[j];
                    s[j] = s[j+1];
                    s[j+1] = t;
                end
            end
        end
        for (int k = 0; k < 4; k++) sb.push_back({(k == 3), s[k]});
        for (int k = 0; k < 4; k++) load_word(w[k], (gmax > 0) ? int'($urandom_range(0, gmax)) : 0);
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_last"},  32'(out_last),  32'd0);
        chk({tag, "_out_data"},  32'(out_data),  32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        sb.delete();
        rst_n = 1'b1;
        #1;
        chk({tag, "_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset("reset");

        // Basic sort plus first-output latency
        load_batch(8'd3, 8'd9, 8'd1, 8'd7, 0);
        repeat (4) begin
            @(negedge clk);
            chk("lat_lo", 32'(out_valid), 32'd0);
            chk("busy_sort", 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("lat_hi", 32'(out_valid), 32'd1);
        wait_empty();

        load_batch(8'd5, 8'd5, 8'd200, 8'd0, 0);
        wait_empty();
        load_batch(8'd0, 8'd255, 8'd128, 8'd255, 0);
        wait_empty();
        load_batch(8'd255, 8'd128, 8'd64, 8'd1, 0);
        wait_empty();

        // Back-to-back without gaps gives the 12-cycle minimum period
        load_batch(8'd1, 8'd2, 8'd3, 8'd4, 0);
        prev = acc_cyc;
        load_batch(8'd8, 8'd6, 8'd7, 8'd5, 0);
        chk("period_min", 32'(acc_cyc - prev), 32'd12);
        wait_empty();

        // Backpressure with in_valid held during drain
        out_ready = 1'b0;
        load_batch(8'd10, 8'd20, 8'd30, 8'd40, 0);
        wait_out_valid();
        in_valid = 1'b1;
        in_data  = 8'd99;
        repeat (5) begin
            @(negedge clk);
            chk("bp_data", 32'(out_data), 32'd40);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("bp_left", 32'(sb.size()), 32'd0);
        out_ready = 1'b1;

        // Reset after two loaded words
        load_word(8'd50, 0);
        load_word(8'd60, 0);
        do_reset("rst_load");
        load_batch(8'd4, 8'd3, 8'd2, 8'd1, 0);
        wait_empty();

        // Reset after the second drained word
        load_batch(8'd11, 8'd22, 8'd33, 8'd44, 0);
        begin
            int n;
            n = 0;
            while (sb.size() > 2 && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("mid_drain_reach", 32'(sb.size()), 32'd2);
        end
        do_reset("rst_drain");
        repeat (8) @(posedge clk);
        #1;
        chk("rst_drain_quiet", 32'(out_valid), 32'd0);

        // Random gapped batches
        prev = -1;
        for (int b = 0; b < 16; b++) begin
            load_batch(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 3);
            if (prev >= 0) chk("period_ge12", 32'((acc_cyc - prev) >= 12), 32'd1);
            prev = acc_cyc;
        end
        wait_empty();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
